// File: rtl/rv_pkg.sv
// Shared RISC-V datapath definitions.
//   XLEN       : architectural register width
//   REGW       : register index width
//   reg_idx_t  : register index type
//   wb_entry_t : one pending writeback {rd, data}
package rv_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned REGW = 5;

  typedef logic [REGW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Combinational search of the writeback queue for a source register.
//   rs       : source register index to look up
//   valid    : per-slot occupied flags
//   entries  : queue storage
//   oldest   : slot index of the oldest entry (queue read pointer)
//   hit      : some occupied slot targets rs (never for rs == x0)
//   data     : value from the youngest matching slot, 0 when no hit
module wb_bypass_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OUT_W = 64
) (
  input  rv_pkg::reg_idx_t  rs,
  input  logic [DEPTH-1:0]  valid,
  input  rv_pkg::wb_entry_t entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] oldest,
  output logic              hit,
  output logic [OUT_W-1:0]  data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [rv_pkg::XLEN-1:0] sel;
  logic [PW-1:0]           idx;

  // Walk from oldest to youngest so later matches override earlier ones.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PW'(32'(oldest) + i);
      if (rs != '0 && valid[idx] && entries[idx].rd == rs) begin
        hit = 1'b1;
        sel = entries[idx].data;
      end
    end
  end

  assign data = OUT_W'(sel);

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register-file write port, with
// decode-stage forwarding from queued entries.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_rd/in_data, in_ready : producer handshake (rd == 0 dropped)
//   rf_we/rf_rd/rf_wdata : register-file write port, head of queue
//   byp_rs1/2            : decode source indices
//   byp_hit1/2, byp_data1/2 : forwarded value from youngest queued match
//   count                : occupied entries
module wb_queue #(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  output logic                     in_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic [4:0]               byp_rs1,
  input  logic [4:0]               byp_rs2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [XLEN-1:0]          byp_data1,
  output logic [XLEN-1:0]          byp_data2,
  output logic [$clog2(DEPTH):0]   count
);

  import rv_pkg::*;

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned PKG_XLEN = rv_pkg::XLEN;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  wb_entry_t        head;

  logic push, pop;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_rd != '0);
  // The register file takes the head every cycle it is presented.
  assign pop      = (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q]   = '{rd: in_rd, data: PKG_XLEN'(in_data)};
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Storage is not reset: every read of it is qualified by count/valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head     = mem_q[rd_ptr_q];
  assign rf_we    = pop;
  assign rf_rd    = pop ? head.rd : '0;
  assign rf_wdata = pop ? XLEN'(head.data) : '0;
  assign count    = count_q;

  wb_bypass_match #(.DEPTH(DEPTH), .OUT_W(XLEN)) u_byp1 (
    .rs      (byp_rs1),
    .valid   (valid_q),
    .entries (mem_q),
    .oldest  (rd_ptr_q),
    .hit     (byp_hit1),
    .data    (byp_data1)
  );

  wb_bypass_match #(.DEPTH(DEPTH), .OUT_W(XLEN)) u_byp2 (
    .rs      (byp_rs2),
    .valid   (valid_q),
    .entries (mem_q),
    .oldest  (rd_ptr_q),
    .hit     (byp_hit2),
    .data    (byp_data2)
  );

endmodule
